// File: rtl/pll_bringup_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : pll_bringup_seq                                                 |
// | Brief  : PLL reset/power-down sequencing, lock supervision with bounded  |
// |          retries, and counter enable gating.                             |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module pll_bringup_seq #(
    parameter int RST_CYCLES    = 4,
    parameter int LOCK_TIMEOUT  = 1024,
    parameter int SETTLE_CYCLES = 256,
    parameter int MAX_RETRY     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       pwrdn_i,
    input  logic       locked_i,
    output logic       pll_rst_o,
    output logic       pll_pwrdn_o,
    output logic       cnt_en_o,
    output logic       cnt_rst_o,
    output logic [2:0] state_o,
    output logic       fault_o,
    output logic [7:0] lol_cnt_o
);

    localparam int c_TMAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int c_TMAX     = (c_TMAX_A > SETTLE_CYCLES) ? c_TMAX_A : SETTLE_CYCLES;
    localparam int c_TIMER_W  = $clog2(c_TMAX + 1);
    localparam int c_RETRY_W  = $clog2(MAX_RETRY + 1);

    localparam logic [c_TIMER_W-1:0] c_RST_LAST    = c_TIMER_W'(RST_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_LOCK_LAST   = c_TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_TIMER_W-1:0] c_SETTLE_LAST = c_TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [c_RETRY_W-1:0] c_MAX_RETRY   = c_RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PWRDN     = 3'd1,
        ST_RESET     = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_SETTLE    = 3'd4,
        ST_RUN       = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_TIMER_W-1:0]   r_timer;
    logic [c_TIMER_W-1:0]   w_timer_nxt;
    logic [c_RETRY_W-1:0]   r_retry;
    logic [c_RETRY_W-1:0]   w_retry_nxt;
    logic [c_RETRY_W-1:0]   w_retry_inc;
    logic [7:0]             r_lol_cnt;
    logic [7:0]             w_lol_nxt;
    logic                   r_lock_meta;
    logic                   r_lock_s;

    // locked_i comes from the PLL and is asynchronous to the board clock
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= locked_i;
            r_lock_s    <= r_lock_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_retry   <= '0;
            r_lol_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_retry   <= w_retry_nxt;
            r_lol_cnt <= w_lol_nxt;
        end
    end

    assign w_retry_inc = r_retry + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_retry_nxt = r_retry;
        w_lol_nxt   = r_lol_cnt;
        if (pwrdn_i) begin
            w_state_nxt = ST_PWRDN;
            w_timer_nxt = '0;
        end else if (r_state == ST_PWRDN) begin
            w_state_nxt = en_i ? ST_RESET : ST_IDLE;
            w_timer_nxt = '0;
            w_retry_nxt = '0;
        end else if (!en_i) begin
            w_state_nxt = ST_IDLE;
            w_timer_nxt = '0;
            w_retry_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_RESET;
                    w_timer_nxt = '0;
                end
                ST_RESET: begin
                    if (r_timer == c_RST_LAST) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    // a lock seen on the timeout cycle takes precedence
                    if (r_lock_s) begin
                        w_state_nxt = ST_SETTLE;
                        w_timer_nxt = '0;
                    end else if (r_timer == c_LOCK_LAST) begin
                        w_retry_nxt = w_retry_inc;
                        w_timer_nxt = '0;
                        w_state_nxt = (w_retry_inc == c_MAX_RETRY) ? ST_FAULT : ST_RESET;
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (!r_lock_s) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_timer_nxt = '0;
                    end else if (r_timer == c_SETTLE_LAST) begin
                        w_state_nxt = ST_RUN;
                        w_timer_nxt = '0;
                        w_retry_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!r_lock_s) begin
                        w_state_nxt = ST_RESET;
                        w_timer_nxt = '0;
                        w_lol_nxt   = (r_lol_cnt == 8'hFF) ? r_lol_cnt : r_lol_cnt + 8'd1;
                    end
                end
                ST_FAULT: begin
                    w_state_nxt = ST_FAULT;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = '0;
                    w_retry_nxt = '0;
                end
            endcase
        end
    end

    assign pll_rst_o   = (r_state == ST_IDLE) || (r_state == ST_PWRDN) ||
                         (r_state == ST_RESET) || (r_state == ST_FAULT);
    assign pll_pwrdn_o = (r_state == ST_PWRDN);
    assign cnt_en_o    = (r_state == ST_RUN);
    assign cnt_rst_o   = (r_state != ST_RUN);
    assign fault_o     = (r_state == ST_FAULT);
    assign state_o     = r_state;
    assign lol_cnt_o   = r_lol_cnt;

endmodule
`default_nettype wire
